// File: rtl/instr_exec_reader_if.sv
// Result handshake between the instruction read-side sequencer and its consumer.
interface instr_exec_reader_if #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32
);
  logic                res_valid;
  logic                res_ready;
  logic [ADDR_W-1:0]   res_addr;
  logic [3:0]          res_opcode;
  logic [2*OP_W-1:0]   res_result;
  logic [1:0]          res_err;

  modport master (
    output res_valid, res_addr, res_opcode, res_result, res_err,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_addr, res_opcode, res_result, res_err,
    output res_ready
  );
endinterface

// File: rtl/instr_exec_reader.sv
// Walks read_pointer over an address window, executes each fetched opcode
// in a signed ALU and presents one result per instruction on a valid/ready port.
module instr_exec_reader #(
  parameter int ADDR_W = 5,
  parameter int OP_W   = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W:0]       count,
  output logic [ADDR_W-1:0]     read_pointer,
  input  logic [4+2*OP_W-1:0]   instruction_word,
  output logic                  busy,
  output logic                  done,
  instr_exec_reader_if.master   res
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_e;
  typedef enum logic [3:0] {
    OP_ZERO, OP_PASSA, OP_PASSB, OP_ADD, OP_SUB, OP_MULT, OP_DIV, OP_MOD
  } opcode_e;

  state_e                  state;
  logic [ADDR_W:0]         remaining;

  logic [3:0]              opc;
  opcode_e                 opc_e;
  logic signed [OP_W-1:0]  op_a;
  logic signed [OP_W-1:0]  op_b;
  logic signed [2*OP_W-1:0] a_x;
  logic signed [2*OP_W-1:0] b_x;
  logic signed [2*OP_W-1:0] alu_res;
  logic [1:0]              alu_err;

  assign opc   = instruction_word[4+2*OP_W-1 -: 4];
  assign opc_e = opcode_e'(opc);
  assign op_a  = instruction_word[2*OP_W-1 -: OP_W];
  assign op_b  = instruction_word[OP_W-1:0];

  // Operate at full result width so MULT is exact and DIV of the most
  // negative value by -1 does not overflow.
  assign a_x = {{OP_W{op_a[OP_W-1]}}, op_a};
  assign b_x = {{OP_W{op_b[OP_W-1]}}, op_b};

  always_comb begin
    alu_res = '0;
    alu_err = '0;
    case (opc_e)
      OP_ZERO:  alu_res = '0;
      OP_PASSA: alu_res = a_x;
      OP_PASSB: alu_res = b_x;
      OP_ADD:   alu_res = a_x + b_x;
      OP_SUB:   alu_res = a_x - b_x;
      OP_MULT:  alu_res = a_x * b_x;
      OP_DIV: begin
        if (op_b == '0) alu_err[0] = 1'b1;
        else            alu_res = a_x / b_x;
      end
      OP_MOD: begin
        if (op_b == '0) alu_err[0] = 1'b1;
        else            alu_res = a_x % b_x;
      end
      default:  alu_err[1] = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      read_pointer   <= '0;
      remaining      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      res.res_valid  <= 1'b0;
      res.res_addr   <= '0;
      res.res_opcode <= '0;
      res.res_result <= '0;
      res.res_err    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              read_pointer <= first_addr;
              remaining    <= count;
              busy         <= 1'b1;
              state        <= EXEC;
            end else begin
              done <= 1'b1;
            end
          end
        end
        EXEC: begin
          res.res_addr   <= read_pointer;
          res.res_opcode <= opc;
          res.res_result <= alu_res;
          res.res_err    <= alu_err;
          res.res_valid  <= 1'b1;
          state          <= HOLD;
        end
        HOLD: begin
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            if (remaining == (ADDR_W+1)'(1)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              remaining    <= remaining - (ADDR_W+1)'(1);
              read_pointer <= read_pointer + ADDR_W'(1);
              state        <= EXEC;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_exec_reader.md
Name: instr_exec_reader

Overview:
- Read-side sequencer for the instruction register.
- On a start command it walks read_pointer across a contiguous address window and samples each instruction_word (combinational read port of the register).
- Executes each opcode in an internal ALU and presents one result per instruction on a valid/ready handshake to a downstream consumer or scoreboard.
- Sits beside the instruction register and replaces bench-driven read_pointer stimulus.

Parameters:
- ADDR_W, 5, read_pointer width; the window wraps modulo 2**ADDR_W. Must equal the address_t width.
- OP_W, 32, signed operand width. Must equal the operand_t width; the result width is 2*OP_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle command; accepted only in IDLE
- first_addr  input  ADDR_W  first register location to read
- count  input  ADDR_W+1  number of instructions to execute, 0..2**ADDR_W
- read_pointer  output  ADDR_W  registered address to the instruction register
- instruction_word  input  4+2*OP_W  {opc[3:0], op_a signed, op_b signed}
- busy  output  1  high in every state except IDLE
- res_valid  output  1  result presented
- res_ready  input  1  consumer accepts result
- res_addr  output  ADDR_W  location the result came from
- res_opcode  output  4  opcode executed
- res_result  output  2*OP_W  signed result
- res_err  output  2  bit0 = divide/modulo by zero; bit1 = illegal opcode (8..15)
- done  output  1  one-cycle pulse when the window is complete

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-run):
  - state = IDLE.
  - read_pointer, res_addr, res_opcode, res_result, res_err, remaining counter = 0.
  - busy, res_valid, done = 0.
  - A run in progress is abandoned; no done pulse is produced.
- States: IDLE, EXEC, HOLD.
- IDLE:
  - start=1 and count!=0: read_pointer<=first_addr, remaining<=count, go to EXEC.
  - start=1 and count==0: done=1 on the next cycle, stay in IDLE.
  - start while busy is ignored.
- EXEC, one cycle: read_pointer is stable; sample instruction_word and register the following, then go to HOLD:
  - res_addr<=read_pointer.
  - res_opcode<=opc.
  - res_result<=ALU(opc, op_a, op_b).
  - res_err.
  - res_valid<=1.
- Latency: res_valid rises 2 clocks after the start edge. Peak throughput is one result per 2 clocks.
- HOLD:
  - All res_* outputs are held stable while res_valid=1 and res_ready=0.
  - On res_valid&res_ready: res_valid<=0.
  - If remaining==1: done<=1 (1 cycle), go to IDLE.
  - Otherwise: remaining--, read_pointer<=read_pointer+1 (wraps 2**ADDR_W-1 -> 0), go to EXEC.
- ALU; operands are signed and all results are sign-extended to 2*OP_W:
  - 0 ZERO -> 0
  - 1 PASSA -> op_a
  - 2 PASSB -> op_b
  - 3 ADD -> op_a+op_b
  - 4 SUB -> op_a-op_b
  - 5 MULT -> full 2*OP_W product
  - 6 DIV -> op_a/op_b, truncating toward zero
  - 7 MOD -> op_a%op_b, sign follows op_a
- Boundary cases:
  - DIV or MOD with op_b==0: result 0, res_err[0]=1.
  - opc 8..15: result 0, res_err[1]=1.
  - count == 2**ADDR_W: every location is read exactly once, starting at first_addr with wrap.
- busy: 1 from the cycle after start acceptance until the cycle done is asserted; 0 in that done cycle.

Test Plan:
- Reset, then first_addr=0, count=3, with locations 0..2 = {ADD,5,3}, {SUB,-15,7}, {MULT,-4,6}, res_ready=1:
  - Results 8, -22, -24 at addrs 0, 1, 2.
  - res_valid first high 2 clocks after start.
  - done pulses once.
- Location 4 = {DIV,-7,2}, location 5 = {MOD,-7,2}, location 6 = {DIV,9,0}, count=3, first_addr=4:
  - Results -3, -1, 0.
  - res_err = 0, 0, 1.
- Backpressure: hold res_ready=0 for 5 clocks on the first result.
  - res_* stable and read_pointer unchanged throughout.
  - Results then proceed in order with no loss or duplication.
- Wrap: first_addr=30, count=4.
  - read_pointer sequence 30, 31, 0, 1.
  - res_addr matches that sequence.
- start with count=0: done high on the next cycle, busy stays 0, no res_valid.
- reset_n driven low while in HOLD on the 2nd of 4 results:
  - All outputs go to their reset values immediately; no done pulse.
  - A new start afterwards runs normally.
- Location 7 = {opc 12, 1, 1}: result 0, res_err=2'b10.
